// File: rtl/d_ip_m_pcrm_pkg.sv
// Shared types for the power-domain sequencer: state encodings, error codes
// and the state-to-control decode used to build the registered outputs.
package d_ip_m_pcrm_pkg;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_SW_ON   = 3'd1,
        S_RST_REL = 3'd2,
        S_CLK_ON  = 3'd3,
        S_ON      = 3'd4,
        S_CLK_OFF = 3'd5,
        S_ISO     = 3'd6,
        S_SW_OFF  = 3'd7
    } pcrm_seq_state_t;

    // An error code equals the encoding of the state in which the error occurred.
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_SW_ON    = 3'd1;
    localparam logic [2:0] ERR_CLK_ON   = 3'd3;
    localparam logic [2:0] ERR_PWR_LOSS = 3'd4;
    localparam logic [2:0] ERR_CLK_OFF  = 3'd5;
    localparam logic [2:0] ERR_ISO      = 3'd6;

    typedef struct packed {
        logic pwr_sw_en;
        logic sync_rst_b;
        logic clk_ack;
        logic pwr_gting_ack;
        logic on_ack;
    } pcrm_seq_out_t;

    function automatic pcrm_seq_out_t pcrm_seq_decode(input pcrm_seq_state_t st,
                                                      input logic in_err);
        pcrm_seq_out_t o;
        o.pwr_sw_en     = 1'b0;
        o.sync_rst_b    = 1'b0;
        o.clk_ack       = 1'b0;
        o.pwr_gting_ack = 1'b1;
        o.on_ack        = 1'b0;
        if (!in_err) begin
            case (st)
                S_OFF: ;
                S_SW_ON: begin
                    o.pwr_sw_en = 1'b1; o.pwr_gting_ack = 1'b0;
                end
                S_RST_REL: begin
                    o.pwr_sw_en = 1'b1; o.pwr_gting_ack = 1'b0; o.sync_rst_b = 1'b1;
                end
                S_CLK_ON: begin
                    o.pwr_sw_en = 1'b1; o.pwr_gting_ack = 1'b0; o.sync_rst_b = 1'b1;
                    o.clk_ack = 1'b1;
                end
                S_ON: begin
                    o.pwr_sw_en = 1'b1; o.pwr_gting_ack = 1'b0; o.sync_rst_b = 1'b1;
                    o.clk_ack = 1'b1; o.on_ack = 1'b1;
                end
                S_CLK_OFF: begin
                    o.pwr_sw_en = 1'b1; o.pwr_gting_ack = 1'b0; o.sync_rst_b = 1'b1;
                    o.on_ack = 1'b1;
                end
                S_ISO: begin
                    o.pwr_sw_en = 1'b1; o.pwr_gting_ack = 1'b0; o.on_ack = 1'b1;
                end
                S_SW_OFF: begin
                    o.on_ack = 1'b1;
                end
            endcase
        end
        return o;
    endfunction

endpackage

// File: rtl/d_ip_m_pcrm_tmr.sv
// Loadable down-counter shared by every timed sequencer state; done is high
// while enabled and the count has reached zero.
module d_ip_m_pcrm_tmr #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             load,
    input  logic             en,
    input  logic [TMO_W-1:0] load_val,
    output logic             done
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - TMO_W'(1);
        end
    end

    assign done = en && (cnt == '0);

endmodule

// File: rtl/d_ip_m_pcrm_seq.sv
// Always-on power-domain sequencer: turns a 4-phase on/off request into the
// ordered switch / reset / clock / gating controls for d_ip_m_pcrm_ctrl.
module d_ip_m_pcrm_seq
    import d_ip_m_pcrm_pkg::*;
#(
    parameter int TMO_W      = 16,
    parameter int TMO_CYC    = 1000,
    parameter int PG_SETTLE  = 8,
    parameter int RST_HOLD   = 4,
    parameter int SW_OFF_DLY = 4
) (
    input  logic       clk,
    input  logic       sync_rst,
    input  logic       on_req,
    output logic       on_ack,
    input  logic       err_clr,
    output logic       err,
    output logic [2:0] err_code,
    input  logic       pwr_good,
    output logic       pwr_sw_en,
    output logic       sync_rst_b,
    output logic       clk_ack,
    output logic       pwr_gting_ack,
    input  logic       vdd_iso_en_b,
    input  logic       clk_gate_en_b,
    input  logic       func_rst_b,
    input  logic       clk_gting_ack
);

    // Timer loads N-1 so that done is sampled exactly N cycles after state entry.
    localparam logic [TMO_W-1:0] TMO_LD      = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0] HOLD_LD     = TMO_W'(RST_HOLD - 1);
    localparam logic [TMO_W-1:0] SWOFF_LD    = TMO_W'(SW_OFF_DLY - 1);
    localparam logic [TMO_W-1:0] SETTLE_LAST = TMO_W'(PG_SETTLE - 1);

    pcrm_seq_state_t  state_q, state_nxt;
    logic             err_q, err_nxt;
    logic [2:0]       err_code_nxt;
    logic [TMO_W-1:0] settle_cnt;
    logic [TMO_W-1:0] tmr_val;
    logic             tmr_load, tmr_en, tmr_done;
    pcrm_seq_out_t    out_nxt;

    d_ip_m_pcrm_tmr #(.TMO_W(TMO_W)) u_tmr (
        .clk      (clk),
        .sync_rst (sync_rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Consecutive-high count of pwr_good, only meaningful while switching on.
    always_ff @(posedge clk) begin
        if (sync_rst || err_q || (state_q != S_SW_ON) || !pwr_good) begin
            settle_cnt <= '0;
        end else begin
            settle_cnt <= settle_cnt + TMO_W'(1);
        end
    end

    always_comb begin
        state_nxt    = state_q;
        err_nxt      = err_q;
        err_code_nxt = err_code;
        if (err_q) begin
            if (err_clr && !on_req) begin
                state_nxt    = S_OFF;
                err_nxt      = 1'b0;
                err_code_nxt = ERR_NONE;
            end
        end else begin
            case (state_q)
                S_OFF: if (on_req) state_nxt = S_SW_ON;
                S_SW_ON: begin
                    if (pwr_good && (settle_cnt == SETTLE_LAST)) begin
                        state_nxt = S_RST_REL;
                    end else if (tmr_done) begin
                        err_nxt = 1'b1; err_code_nxt = ERR_SW_ON;
                    end
                end
                S_RST_REL: if (tmr_done) state_nxt = S_CLK_ON;
                S_CLK_ON: begin
                    if (func_rst_b && vdd_iso_en_b) begin
                        state_nxt = S_ON;
                    end else if (tmr_done) begin
                        err_nxt = 1'b1; err_code_nxt = ERR_CLK_ON;
                    end
                end
                S_ON: begin
                    if (!pwr_good) begin
                        err_nxt = 1'b1; err_code_nxt = ERR_PWR_LOSS;
                    end else if (!on_req) begin
                        state_nxt = S_CLK_OFF;
                    end
                end
                S_CLK_OFF: begin
                    if (!clk_gate_en_b && clk_gting_ack) begin
                        state_nxt = S_ISO;
                    end else if (tmr_done) begin
                        err_nxt = 1'b1; err_code_nxt = ERR_CLK_OFF;
                    end
                end
                S_ISO: begin
                    if (!vdd_iso_en_b) begin
                        state_nxt = S_SW_OFF;
                    end else if (tmr_done) begin
                        err_nxt = 1'b1; err_code_nxt = ERR_ISO;
                    end
                end
                S_SW_OFF: if (tmr_done) state_nxt = S_OFF;
            endcase
        end
    end

    always_comb begin
        tmr_load = (state_nxt != state_q) || (err_nxt != err_q);
        tmr_en   = !err_q;
        tmr_val  = TMO_LD;
        if (state_nxt == S_RST_REL) begin
            tmr_val = HOLD_LD;
        end else if (state_nxt == S_SW_OFF) begin
            tmr_val = SWOFF_LD;
        end
    end

    assign out_nxt = pcrm_seq_decode(state_nxt, err_nxt);

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q       <= S_OFF;
            err_q         <= 1'b0;
            err_code      <= ERR_NONE;
            pwr_sw_en     <= 1'b0;
            sync_rst_b    <= 1'b0;
            clk_ack       <= 1'b0;
            pwr_gting_ack <= 1'b1;
            on_ack        <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            err_q         <= err_nxt;
            err_code      <= err_code_nxt;
            pwr_sw_en     <= out_nxt.pwr_sw_en;
            sync_rst_b    <= out_nxt.sync_rst_b;
            clk_ack       <= out_nxt.clk_ack;
            pwr_gting_ack <= out_nxt.pwr_gting_ack;
            on_ack        <= out_nxt.on_ack;
        end
    end

    assign err = err_q;

    a_clk_ack_safe: assert property (@(posedge clk) disable iff (sync_rst)
        clk_ack |-> (sync_rst_b && pwr_sw_en));

endmodule
